// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among four requesters, with a
// synchronized chip-select handshake and a per-transaction abort timer.
module spi_arbiter #(
   parameter int TIMEOUT_CYC = 4000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [47:0] din_bus,
   output logic [3:0]  gnt,
   output logic [3:0]  done,
   output logic        err,
   output logic        spi_newd,
   output logic [11:0] spi_din,
   input  logic        spi_cs
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LAUNCH = 2'd1;
   localparam logic [1:0] BUSY   = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam logic [31:0] CNT_LIMIT = 32'(TIMEOUT_CYC - 1);

   logic [1:0]  state;
   logic        cs_m, cs_s;
   logic [3:0]  req_q, pend, rq, win_oh;
   logic [1:0]  last, cur, win, idx;
   logic        found, active, timeout;
   logic [31:0] cnt;

   // Search starts just past the last granted index so every requester gets a turn.
   always_comb begin
      rq     = req | pend;
      win    = last;
      idx    = last;
      found  = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = last + 2'(k);
         if (!found && rq[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      win_oh = found ? (4'b0001 << win) : 4'b0000;
   end

   assign active  = (state == LAUNCH) || (state == BUSY);
   assign timeout = active && ((cnt + 32'd1) == CNT_LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cs_m     <= 1'b1;
         cs_s     <= 1'b1;
         req_q    <= 4'b0000;
         pend     <= 4'b0000;
         gnt      <= 4'b0000;
         done     <= 4'b0000;
         err      <= 1'b0;
         spi_newd <= 1'b0;
         spi_din  <= 12'h000;
         cnt      <= 32'd0;
         last     <= 2'd3;
         cur      <= 2'd0;
      end else begin
         cs_m  <= spi_cs;
         cs_s  <= cs_m;
         req_q <= req;
         // Short request pulses that lose arbitration are remembered until granted.
         pend  <= (pend | (req & ~req_q)) & ~((state == IDLE) ? win_oh : 4'b0000);
         done  <= 4'b0000;
         err   <= 1'b0;

         case (state)
            IDLE: begin
               if (found) begin
                  state    <= LAUNCH;
                  gnt      <= win_oh;
                  cur      <= win;
                  spi_din  <= din_bus[12*win +: 12];
                  spi_newd <= 1'b1;
                  cnt      <= 32'd0;
               end
            end
            LAUNCH, BUSY: begin
               cnt <= cnt + 32'd1;
               if (timeout) begin
                  state    <= IDLE;
                  err      <= 1'b1;
                  spi_newd <= 1'b0;
                  gnt      <= 4'b0000;
                  last     <= cur;
               end else if (state == LAUNCH && !cs_s) begin
                  state    <= BUSY;
                  spi_newd <= 1'b0;
               end else if (state == BUSY && cs_s) begin
                  state <= DONE;
                  done  <= gnt;
               end
            end
            DONE: begin
               state <= IDLE;
               gnt   <= 4'b0000;
               last  <= cur;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: grant/word/done scoreboard plus per-scenario checks.
module tb_spi_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [47:0] din_bus;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic        err;
   logic        spi_newd;
   logic [11:0] spi_din;
   logic        spi_cs;

   int n_pass  = 0;
   int n_total = 0;

   bit spi_en   = 1'b1;
   bit auto_rel = 1'b1;

   typedef struct {
      logic [3:0]  g;
      logic [11:0] d;
   } exp_t;
   exp_t exp_q[$];

   logic [11:0] words [4] = '{12'hA5C, 12'h3B1, 12'h7E2, 12'hC43};

   spi_arbiter #(.TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst), .req(req), .din_bus(din_bus), .gnt(gnt),
      .done(done), .err(err), .spi_newd(spi_newd), .spi_din(spi_din), .spi_cs(spi_cs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SPI master model: cs falls 2 cycles after the start strobe, rises 4 cycles later.
   initial begin
      int mc;
      mc = 0;
      spi_cs = 1'b1;
      forever begin
         @(negedge clk);
         if (rst || !spi_en) begin
            spi_cs = 1'b1;
            mc = 0;
         end else if (mc == 0) begin
            if (spi_newd) mc = 1;
         end else begin
            mc++;
            if (mc == 3) spi_cs = 1'b0;
            else if (mc == 7) spi_cs = 1'b1;
            else if (mc > 7 && !spi_newd) mc = 0;
         end
      end
   end

   // Scoreboard: every new grant pops its expected requester and word.
   initial begin
      logic [3:0] prev;
      exp_t e;
      prev = 4'b0000;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 4'b0000;
         end else begin
            n_total++;
            if (!$onehot0(gnt)) $display("FAIL gnt_onehot got %b want at most one bit", gnt);
            else n_pass++;
            n_total++;
            if ((|done) && err) $display("FAIL done_err_overlap got done=%b err=%b want not both", done, err);
            else n_pass++;
            if (gnt != 4'b0000 && prev == 4'b0000) begin
               n_total++;
               if (exp_q.size() == 0) begin
                  $display("FAIL grant_unexpected got gnt=%b want no grant", gnt);
               end else begin
                  e = exp_q.pop_front();
                  if (gnt !== e.g) $display("FAIL grant_order got %b want %b", gnt, e.g);
                  else n_pass++;
                  n_total++;
                  if (spi_din !== e.d) $display("FAIL grant_word got %h want %h", spi_din, e.d);
                  else n_pass++;
               end
            end
            if (|done) begin
               n_total++;
               if (done !== gnt) $display("FAIL done_match got done=%b want %b", done, gnt);
               else n_pass++;
            end
            prev = gnt;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog got timeout want $finish");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(input int i);
      exp_t e;
      e.g = 4'b0001 << i;
      e.d = words[i];
      return e;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      req = 4'b0000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_done(input int n, input int budget, output bit ok, output logic [3:0] dv);
      int c;
      c = 0;
      ok = 1'b0;
      dv = 4'b0000;
      for (int t = 0; t < budget; t++) begin
         @(negedge clk);
         if (|done) begin
            c++;
            dv = done;
            if (auto_rel) req = req & ~done;
            if (c == n) begin
               ok = 1'b1;
               break;
            end
         end
      end
   endtask

   task automatic wait_busy(output bit ok);
      bit seen;
      seen = 1'b0;
      ok = 1'b0;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (spi_newd) seen = 1'b1;
         else if (seen) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 4'b0000;
      repeat (2) @(negedge clk);
      n_total++; if (gnt !== 4'b0000) $display("FAIL rst_gnt got %b want 0000", gnt); else n_pass++;
      n_total++; if (done !== 4'b0000) $display("FAIL rst_done got %b want 0000", done); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err); else n_pass++;
      n_total++; if (spi_newd !== 1'b0) $display("FAIL rst_newd got %b want 0", spi_newd); else n_pass++;
      n_total++; if (spi_din !== 12'h000) $display("FAIL rst_din got %h want 000", spi_din); else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_single();
      bit ok;
      logic [3:0] dv;
      auto_rel = 1'b1;
      exp_q.push_back(mk(0));
      req = 4'b0001;
      wait_done(1, 100, ok, dv);
      n_total++; if (!ok || dv !== 4'b0001) $display("FAIL single_done got ok=%0d done=%b want 0001", ok, dv); else n_pass++;
      @(negedge clk);
      n_total++; if (gnt !== 4'b0000) $display("FAIL single_gnt_clear got %b want 0000", gnt); else n_pass++;
      n_total++; if (done !== 4'b0000) $display("FAIL single_done_once got %b want 0000", done); else n_pass++;
   endtask

   task automatic test_contention();
      bit ok;
      logic [3:0] dv;
      do_reset();
      auto_rel = 1'b0;
      for (int i = 0; i < 5; i++) exp_q.push_back(mk(i % 4));
      req = 4'b1111;
      wait_done(5, 300, ok, dv);
      req = 4'b0000;
      auto_rel = 1'b1;
      n_total++; if (!ok || dv !== 4'b0001) $display("FAIL contention_fifth got ok=%0d done=%b want 0001", ok, dv); else n_pass++;
      repeat (5) @(negedge clk);
      n_total++; if (gnt !== 4'b0000) $display("FAIL contention_idle got %b want 0000", gnt); else n_pass++;
   endtask

   task automatic test_rr_after2();
      bit ok;
      logic [3:0] dv;
      do_reset();
      exp_q.push_back(mk(2));
      req = 4'b0100;
      wait_done(1, 100, ok, dv);
      exp_q.push_back(mk(0));
      exp_q.push_back(mk(2));
      req = 4'b0101;
      wait_done(2, 200, ok, dv);
      n_total++; if (!ok || dv !== 4'b0100) $display("FAIL rr_second got ok=%0d done=%b want 0100", ok, dv); else n_pass++;
   endtask

   task automatic test_timeout();
      bit ok;
      logic [3:0] dv;
      int newd_cyc, errs, dones;
      newd_cyc = 0; errs = 0; dones = 0;
      spi_en = 1'b0;
      exp_q.push_back(mk(0));
      req = 4'b0001;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (spi_newd) newd_cyc++;
         if (|done) dones++;
         if (err) begin
            errs++;
            req = 4'b0000;
            n_total++; if (gnt !== 4'b0000) $display("FAIL to_gnt got %b want 0000", gnt); else n_pass++;
            n_total++; if (spi_newd !== 1'b0) $display("FAIL to_newd got %b want 0", spi_newd); else n_pass++;
            break;
         end
      end
      @(negedge clk);
      if (err) errs++;
      n_total++; if (errs != 1) $display("FAIL to_err_count got %0d want 1", errs); else n_pass++;
      n_total++; if (newd_cyc != 15) $display("FAIL to_newd_cycles got %0d want 15", newd_cyc); else n_pass++;
      n_total++; if (dones != 0) $display("FAIL to_no_done got %0d want 0", dones); else n_pass++;
      spi_en = 1'b1;
      exp_q.push_back(mk(1));
      exp_q.push_back(mk(0));
      req = 4'b0011;
      wait_done(2, 200, ok, dv);
      n_total++; if (!ok || dv !== 4'b0001) $display("FAIL to_next_grant got ok=%0d done=%b want 0001", ok, dv); else n_pass++;
   endtask

   task automatic test_drop();
      bit ok;
      logic [3:0] dv;
      exp_q.push_back(mk(1));
      req = 4'b0010;
      wait_busy(ok);
      n_total++; if (!ok) $display("FAIL drop_busy got no busy want busy"); else n_pass++;
      req = 4'b0000;
      wait_done(1, 100, ok, dv);
      n_total++; if (!ok || dv !== 4'b0010) $display("FAIL drop_done got ok=%0d done=%b want 0010", ok, dv); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [3:0] dv;
      exp_q.push_back(mk(0));
      req = 4'b0001;
      wait_busy(ok);
      rst = 1'b1;
      req = 4'b0000;
      @(negedge clk);
      n_total++; if (gnt !== 4'b0000) $display("FAIL mid_gnt got %b want 0000", gnt); else n_pass++;
      n_total++; if (done !== 4'b0000 || err !== 1'b0) $display("FAIL mid_pulse got done=%b err=%b want 0", done, err); else n_pass++;
      n_total++; if (spi_newd !== 1'b0 || spi_din !== 12'h000) $display("FAIL mid_spi got newd=%b din=%h want 0/000", spi_newd, spi_din); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(mk(3));
      req = 4'b1000;
      wait_done(1, 100, ok, dv);
      n_total++; if (!ok || dv !== 4'b1000) $display("FAIL mid_regrant got ok=%0d done=%b want 1000", ok, dv); else n_pass++;
   endtask

   initial begin
      rst = 1'b1;
      req = 4'b0000;
      din_bus = {words[3], words[2], words[1], words[0]};
      test_reset();
      test_single();
      test_contention();
      test_rr_after2();
      test_timeout();
      test_drop();
      test_reset_mid();
      repeat (5) @(negedge clk);
      n_total++; if (exp_q.size() != 0) $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
